// File: rtl/mem_bus_arbiter.sv
// Registered arbiter sharing one memory port between the CPU and FPU masters.
// CPU-first priority with FPU aging, per-transaction timeout and grant counters.
module mem_bus_arbiter #(
  parameter int unsigned MAX_WAIT  = 4,
  parameter int unsigned TIMEOUT   = 64,
  parameter int unsigned CNT_WIDTH = 16
) (
  input  logic                 clk,
  input  logic                 reset,
  input  logic                 cpu_valid,
  input  logic                 cpu_instr,
  input  logic [31:0]          cpu_addr,
  input  logic [31:0]          cpu_wdata,
  input  logic [3:0]           cpu_wstrb,
  output logic                 cpu_ready,
  output logic [31:0]          cpu_rdata,
  input  logic                 fpu_valid,
  input  logic [31:0]          fpu_addr,
  input  logic [31:0]          fpu_wdata,
  input  logic [3:0]           fpu_wstrb,
  output logic                 fpu_ready,
  output logic [31:0]          fpu_rdata,
  output logic                 mem_valid,
  output logic                 mem_instr,
  output logic [31:0]          mem_addr,
  output logic [31:0]          mem_wdata,
  output logic [3:0]           mem_wstrb,
  input  logic                 mem_ready,
  input  logic [31:0]          mem_rdata,
  output logic [1:0]           grant_owner,
  output logic                 timeout_err,
  output logic [CNT_WIDTH-1:0] cpu_grants,
  output logic [CNT_WIDTH-1:0] fpu_grants
);

  localparam int unsigned WaitW = $clog2(MAX_WAIT + 1);
  localparam int unsigned ToW   = $clog2(TIMEOUT);

  // Encoding doubles as the grant_owner value.
  typedef enum logic [1:0] {
    StIdle = 2'b00,
    StCpu  = 2'b01,
    StFpu  = 2'b10
  } state_e;

  state_e               state_q;
  logic [WaitW-1:0]     wait_cnt_q;
  logic [ToW-1:0]       to_cnt_q;
  logic                 timeout_err_q;
  logic [CNT_WIDTH-1:0] cpu_grants_q;
  logic [CNT_WIDTH-1:0] fpu_grants_q;

  logic granted;
  logic timeout_hit;
  logic fpu_aged;

  assign granted     = (state_q != StIdle);
  assign timeout_hit = granted && !mem_ready && (to_cnt_q == ToW'(TIMEOUT - 1));
  assign fpu_aged    = (wait_cnt_q >= WaitW'(MAX_WAIT));

  always_ff @(posedge clk) begin
    if (reset) begin
      state_q       <= StIdle;
      wait_cnt_q    <= '0;
      to_cnt_q      <= '0;
      timeout_err_q <= 1'b0;
      cpu_grants_q  <= '0;
      fpu_grants_q  <= '0;
    end else begin
      unique case (state_q)
        StIdle: begin
          to_cnt_q <= '0;
          if (fpu_valid && fpu_aged) begin
            state_q <= StFpu;
          end else if (cpu_valid) begin
            state_q <= StCpu;
          end else if (fpu_valid) begin
            state_q <= StFpu;
          end
        end
        StCpu, StFpu: begin
          if (mem_ready) begin
            state_q <= StIdle;
            if (state_q == StCpu) begin
              cpu_grants_q <= cpu_grants_q + CNT_WIDTH'(1);
            end else begin
              fpu_grants_q <= fpu_grants_q + CNT_WIDTH'(1);
            end
          end else if (timeout_hit) begin
            state_q       <= StIdle;
            timeout_err_q <= 1'b1;
          end else begin
            to_cnt_q <= to_cnt_q + ToW'(1);
          end
        end
        default: state_q <= StIdle;
      endcase

      // Age clears when the FPU wins arbitration, otherwise saturates while it waits.
      if ((state_q == StIdle) && fpu_valid && (fpu_aged || !cpu_valid)) begin
        wait_cnt_q <= '0;
      end else if (fpu_valid && (state_q != StFpu) && !fpu_aged) begin
        wait_cnt_q <= wait_cnt_q + WaitW'(1);
      end
    end
  end

  always_comb begin
    mem_valid = granted;
    mem_instr = 1'b0;
    mem_addr  = '0;
    mem_wdata = '0;
    mem_wstrb = '0;
    cpu_ready = 1'b0;
    cpu_rdata = '0;
    fpu_ready = 1'b0;
    fpu_rdata = '0;
    unique case (state_q)
      StCpu: begin
        mem_instr = cpu_instr;
        mem_addr  = cpu_addr;
        mem_wdata = cpu_wdata;
        mem_wstrb = cpu_wstrb;
        cpu_ready = mem_ready || timeout_hit;
        cpu_rdata = timeout_hit ? 32'h0 : mem_rdata;
      end
      StFpu: begin
        mem_addr  = fpu_addr;
        mem_wdata = fpu_wdata;
        mem_wstrb = fpu_wstrb;
        fpu_ready = mem_ready || timeout_hit;
        fpu_rdata = timeout_hit ? 32'h0 : mem_rdata;
      end
      default: ;
    endcase
  end

  assign grant_owner = state_q;
  assign timeout_err = timeout_err_q;
  assign cpu_grants  = cpu_grants_q;
  assign fpu_grants  = fpu_grants_q;

endmodule

// File: tb/tb_mem_bus_arbiter.sv
// Bench for mem_bus_arbiter: directed scenarios plus random two-master traffic, checked by a
// per-master response scoreboard and a transaction-level arbitration model.
module tb_mem_bus_arbiter;

  localparam int MaxWait  = 4;
  localparam int Timeout  = 64;
  localparam int CntWidth = 16;

  logic clk, reset;
  logic cpu_valid, cpu_instr, cpu_ready;
  logic [31:0] cpu_addr, cpu_wdata, cpu_rdata;
  logic [3:0] cpu_wstrb;
  logic fpu_valid, fpu_ready;
  logic [31:0] fpu_addr, fpu_wdata, fpu_rdata;
  logic [3:0] fpu_wstrb;
  logic mem_valid, mem_instr, mem_ready;
  logic [31:0] mem_addr, mem_wdata, mem_rdata;
  logic [3:0] mem_wstrb;
  logic [1:0] grant_owner;
  logic timeout_err;
  logic [CntWidth-1:0] cpu_grants, fpu_grants;

  mem_bus_arbiter #(.MAX_WAIT(MaxWait), .TIMEOUT(Timeout), .CNT_WIDTH(CntWidth)) dut (
    .clk(clk), .reset(reset),
    .cpu_valid(cpu_valid), .cpu_instr(cpu_instr), .cpu_addr(cpu_addr), .cpu_wdata(cpu_wdata),
    .cpu_wstrb(cpu_wstrb), .cpu_ready(cpu_ready), .cpu_rdata(cpu_rdata),
    .fpu_valid(fpu_valid), .fpu_addr(fpu_addr), .fpu_wdata(fpu_wdata), .fpu_wstrb(fpu_wstrb),
    .fpu_ready(fpu_ready), .fpu_rdata(fpu_rdata),
    .mem_valid(mem_valid), .mem_instr(mem_instr), .mem_addr(mem_addr), .mem_wdata(mem_wdata),
    .mem_wstrb(mem_wstrb), .mem_ready(mem_ready), .mem_rdata(mem_rdata),
    .grant_owner(grant_owner), .timeout_err(timeout_err),
    .cpu_grants(cpu_grants), .fpu_grants(fpu_grants)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  int n_cmp = 0;
  int n_fail = 0;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %h expected %h (t=%0t)", name, act, exp, $time);
    end
  endtask

  // Memory: latency taken from addr[3:2] (xor lat_xor), addr[9] means it never answers.
  logic [1:0]  lat_xor = 2'd0;
  logic        mem_fixed_en = 1'b0;
  logic [31:0] mem_fixed = 32'h0;
  int          mem_cyc = 0;

  function automatic int lat_of(input logic [31:0] a);
    logic [1:0] l;
    l = a[3:2] ^ lat_xor;
    return int'(l);
  endfunction
  function automatic logic is_stuck(input logic [31:0] a);
    return a[9];
  endfunction
  function automatic logic [31:0] mem_fn(input logic [31:0] a);
    return (a * 32'h9E37_79B1) ^ 32'h5A5A_0F0F;
  endfunction

  always_comb begin
    mem_ready = mem_valid && !is_stuck(mem_addr) && (mem_cyc == lat_of(mem_addr));
    mem_rdata = mem_fixed_en ? mem_fixed : mem_fn(mem_addr);
  end
  always @(posedge clk) mem_cyc <= (mem_valid && !mem_ready) ? mem_cyc + 1 : 0;

  // Scoreboard: expected read data per master, pushed at issue time.
  logic [31:0] cpu_exp_q[$];
  logic [31:0] fpu_exp_q[$];

  // Transaction-level reference: who holds the bus, on which grant cycle it ends, FPU age.
  int m_owner = 0, m_idx = 0, m_end = 0, m_age = 0;
  bit m_abort = 0, m_err = 0;
  int m_cpu_cnt = 0, m_fpu_cnt = 0;
  bit mon_en = 0;

  always @(negedge clk) begin
    int nxt;
    logic [31:0] a;
    if (mon_en) begin
      check("grant_owner", 32'(grant_owner), 32'(m_owner));
      check("mem_valid", 32'(mem_valid), 32'(m_owner != 0));
      check("cpu_ready", 32'(cpu_ready), 32'(m_owner == 1 && m_idx == m_end));
      check("fpu_ready", 32'(fpu_ready), 32'(m_owner == 2 && m_idx == m_end));
      check("mem_addr", mem_addr, m_owner == 1 ? cpu_addr : m_owner == 2 ? fpu_addr : 32'h0);
      check("mem_wdata", mem_wdata, m_owner == 1 ? cpu_wdata : m_owner == 2 ? fpu_wdata : 32'h0);
      check("mem_wstrb", 32'(mem_wstrb),
            32'(m_owner == 1 ? cpu_wstrb : m_owner == 2 ? fpu_wstrb : 4'h0));
      check("mem_instr", 32'(mem_instr), 32'(m_owner == 1 ? cpu_instr : 1'b0));
      check("timeout_err", 32'(timeout_err), 32'(m_err));
      check("cpu_grants", 32'(cpu_grants), m_cpu_cnt % (1 << CntWidth));
      check("fpu_grants", 32'(fpu_grants), m_fpu_cnt % (1 << CntWidth));
      if (m_owner != 1) check("cpu_rdata_idle", cpu_rdata, 32'h0);
      if (m_owner != 2) check("fpu_rdata_idle", fpu_rdata, 32'h0);
      if (cpu_ready) begin
        if (cpu_exp_q.size() == 0) check("cpu_unexpected_ready", 32'h1, 32'h0);
        else check("cpu_rdata", cpu_rdata, cpu_exp_q.pop_front());
      end
      if (fpu_ready) begin
        if (fpu_exp_q.size() == 0) check("fpu_unexpected_ready", 32'h1, 32'h0);
        else check("fpu_rdata", fpu_rdata, fpu_exp_q.pop_front());
      end
    end
    if (reset) begin
      m_owner = 0; m_idx = 0; m_end = 0; m_age = 0; m_abort = 0; m_err = 0;
      m_cpu_cnt = 0; m_fpu_cnt = 0;
    end else begin
      nxt = m_owner;
      if (m_owner != 0) begin
        if (m_idx == m_end) begin
          nxt = 0;
          if (m_abort) m_err = 1;
          else if (m_owner == 1) m_cpu_cnt++;
          else m_fpu_cnt++;
        end else begin
          m_idx++;
        end
      end else begin
        if (fpu_valid && m_age >= MaxWait) nxt = 2;
        else if (cpu_valid) nxt = 1;
        else if (fpu_valid) nxt = 2;
        if (nxt != 0) begin
          a = (nxt == 1) ? cpu_addr : fpu_addr;
          m_abort = is_stuck(a);
          m_end = m_abort ? Timeout - 1 : lat_of(a);
          m_idx = 0;
        end
      end
      if (fpu_valid && m_owner != 2) m_age = (m_age + 1 > MaxWait) ? MaxWait : m_age + 1;
      if (m_owner == 0 && nxt == 2) m_age = 0;
      m_owner = nxt;
    end
  end

  // Issue one transaction on master `who` (1 CPU, 2 FPU); k = cycles from issue to ready.
  task automatic txn(input int who, input logic [31:0] a, input logic [31:0] wd,
                     input logic [3:0] ws, input logic ins, output int k);
    logic [31:0] exp;
    logic rdy;
    exp = is_stuck(a) ? 32'h0 : (mem_fixed_en ? mem_fixed : mem_fn(a));
    if (who == 1) begin
      cpu_valid = 1'b1; cpu_addr = a; cpu_wdata = wd; cpu_wstrb = ws; cpu_instr = ins;
      cpu_exp_q.push_back(exp);
    end else begin
      fpu_valid = 1'b1; fpu_addr = a; fpu_wdata = wd; fpu_wstrb = ws;
      fpu_exp_q.push_back(exp);
    end
    k = 0;
    rdy = 1'b0;
    while (!rdy && k < 2000) begin
      @(negedge clk);
      rdy = (who == 1) ? cpu_ready : fpu_ready;
      if (!rdy) k++;
    end
    if (!rdy) check("ready_wait_budget", 32'(k), 32'(0));
    @(posedge clk);
    #1;
    if (who == 1) begin
      cpu_valid = 1'b0; cpu_addr = '0; cpu_wdata = '0; cpu_wstrb = '0; cpu_instr = 1'b0;
    end else begin
      fpu_valid = 1'b0; fpu_addr = '0; fpu_wdata = '0; fpu_wstrb = '0;
    end
  endtask

  function automatic logic [31:0] rand_addr();
    logic [31:0] a;
    a = $urandom;
    a[9] = ($urandom_range(0, 19) == 0);
    return a;
  endfunction

  task automatic idle(input int n);
    repeat (n) begin
      @(posedge clk);
      #1;
    end
  endtask

  initial begin
    int k;
    reset = 1'b1;
    cpu_valid = 0; cpu_instr = 0; cpu_addr = 0; cpu_wdata = 0; cpu_wstrb = 0;
    fpu_valid = 0; fpu_addr = 0; fpu_wdata = 0; fpu_wstrb = 0;
    idle(3);
    reset = 1'b0;
    mon_en = 1'b1;

    // CPU read, zero-wait memory with fixed data.
    mem_fixed_en = 1'b1; mem_fixed = 32'h1234_5678;
    txn(1, 32'h100, 32'h0, 4'h0, 1'b1, k);
    check("cpu_first_latency", 32'(k), 32'd1);
    mem_fixed_en = 1'b0;
    idle(2);
    check("cpu_grants_after_read", 32'(cpu_grants), 32'd1);

    // Both masters held: CPU twice, then the aged FPU in cycle 5.
    fork
      begin
        int kc;
        for (int i = 0; i < 3; i++) txn(1, 32'h10, 32'h0, 4'h0, 1'b0, kc);
      end
      begin
        int kf;
        txn(2, 32'h20, 32'h0, 4'h0, 1'b0, kf);
        check("fpu_aged_latency", 32'(kf), 32'd5);
      end
    join
    idle(2);

    // FPU write with 3 wait states.
    lat_xor = 2'd3;
    txn(2, 32'h2000, 32'hCAFE_F00D, 4'hF, 1'b0, k);
    check("fpu_write_latency", 32'(k), 32'd4);
    lat_xor = 2'd0;
    idle(2);

    // CPU timeout, then a normal FPU access.
    txn(1, 32'h300, 32'h0, 4'h0, 1'b0, k);
    check("cpu_timeout_latency", 32'(k), 32'(Timeout));
    check("timeout_err_set", 32'(timeout_err), 32'd1);
    txn(2, 32'h40, 32'h0, 4'h0, 1'b0, k);
    check("fpu_after_timeout", 32'(k), 32'd1);
    idle(2);

    // Reset in the second cycle of a stalled FPU grant: no acknowledge.
    fpu_valid = 1'b1; fpu_addr = 32'h200;
    idle(2);
    reset = 1'b1;
    idle(1);
    reset = 1'b0; fpu_valid = 1'b0; fpu_addr = 0;
    @(negedge clk);
    check("post_reset_mem_valid", 32'(mem_valid), 32'd0);
    check("post_reset_owner", 32'(grant_owner), 32'd0);
    check("post_reset_err", 32'(timeout_err), 32'd0);
    check("post_reset_fpu_grants", 32'(fpu_grants), 32'd0);
    idle(2);

    // Random concurrent traffic.
    fork
      begin
        int kc;
        for (int i = 0; i < 50; i++) begin
          idle($urandom_range(0, 3));
          txn(1, rand_addr(), $urandom, 4'($urandom), 1'($urandom), kc);
        end
      end
      begin
        int kf;
        for (int i = 0; i < 50; i++) begin
          idle($urandom_range(0, 3));
          txn(2, rand_addr(), $urandom, 4'($urandom), 1'b0, kf);
        end
      end
    join
    idle(4);
    check("cpu_queue_drained", 32'(cpu_exp_q.size()), 32'd0);
    check("fpu_queue_drained", 32'(fpu_exp_q.size()), 32'd0);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
    $finish;
  end

endmodule

// File: doc/mem_bus_arbiter.md
Name: mem_bus_arbiter

Overview:
- Registered arbiter that shares the single unified instruction/data memory port between the picorv32 native memory interface (CPU) and the SRFPU load/store port (FPU).
- Replaces the ad-hoc combinational mux in the top level with the following:
  - an explicit grant FSM;
  - CPU-first priority with FPU aging, so the FPU cannot starve;
  - a per-transaction timeout;
  - grant counters for performance debug.
- Sits between both masters and the memory module.

Parameters:
MAX_WAIT, 4, cycles an FPU request may wait before it beats the CPU in arbitration (>=1)
TIMEOUT, 64, grant cycles without mem_ready before the transaction is aborted (>=2)
CNT_WIDTH, 16, width of the grant counters

Ports:
clk  in  1  clock
reset  in  1  synchronous, active-high reset
cpu_valid  in  1  CPU request; held with addr/wdata/wstrb until cpu_ready
cpu_instr  in  1  CPU instruction-fetch flag
cpu_addr  in  32  CPU address
cpu_wdata  in  32  CPU write data
cpu_wstrb  in  4  CPU byte strobes; 0 = read
cpu_ready  out  1  CPU transfer-complete pulse
cpu_rdata  out  32  CPU read data, valid with cpu_ready
fpu_valid  in  1  FPU request
fpu_addr  in  32  FPU address
fpu_wdata  in  32  FPU write data
fpu_wstrb  in  4  FPU byte strobes
fpu_ready  out  1  FPU transfer-complete pulse
fpu_rdata  out  32  FPU read data
mem_valid  out  1  request to memory
mem_instr  out  1  forwarded cpu_instr; 0 when FPU is granted
mem_addr  out  32  muxed address
mem_wdata  out  32  muxed write data
mem_wstrb  out  4  muxed strobes
mem_ready  in  1  memory completion
mem_rdata  in  32  memory read data
grant_owner  out  2  00 none, 01 CPU, 10 FPU
timeout_err  out  1  sticky timeout flag
cpu_grants  out  CNT_WIDTH  completed CPU transactions (wrapping)
fpu_grants  out  CNT_WIDTH  completed FPU transactions (wrapping)

Behaviour:
- FSM states: IDLE, CPU_GNT, FPU_GNT. The state is registered; all outputs are decoded from the state.
- Reset (synchronous, any state, including mid-transaction):
  - state=IDLE; wait_cnt, to_cnt, both grant counters and timeout_err return to 0.
  - mem_valid, cpu_ready and fpu_ready are 0 from the cycle after the reset edge.
  - An aborted transaction is not acknowledged.
- IDLE:
  - mem_valid=0, all mem_* outputs 0, both ready outputs 0.
  - Arbitration (registered, takes effect the next cycle):
    - fpu_valid && wait_cnt>=MAX_WAIT → FPU_GNT;
    - else cpu_valid → CPU_GNT;
    - else fpu_valid → FPU_GNT;
    - else stay IDLE.
- X_GNT (X = CPU or FPU):
  - mem_valid=1; mem_addr/wdata/wstrb are driven from X's inputs.
  - mem_instr = cpu_instr in CPU_GNT, 0 in FPU_GNT.
  - x_ready = mem_ready (same cycle, combinational); x_rdata = mem_rdata.
  - The non-granted ready is 0 and its rdata is 0.
- Completion (mem_ready=1 in X_GNT):
  - x_ready pulses for exactly that cycle.
  - Next state is always IDLE: there is one dead cycle between transactions.
  - x_grants increments.
- Latency:
  - A request in IDLE at cycle N is granted in N+1.
  - With zero-wait memory, x_ready is asserted in N+1.
- Aging: wait_cnt (saturating at MAX_WAIT) increments every cycle with fpu_valid=1 and state!=FPU_GNT. It clears on entry to FPU_GNT.
- Timeout:
  - to_cnt clears on entering a grant state and counts grant cycles with mem_ready=0.
  - On the TIMEOUT-th grant cycle with mem_ready still 0, the transaction is aborted:
    - x_ready=1 and x_rdata=32'h0 that cycle;
    - timeout_err is set (sticky until reset);
    - the grant counter is not incremented;
    - next state is IDLE.
- Requester valid deasserting mid-grant is a protocol violation; the arbiter holds the grant until completion or timeout regardless.
- Counters wrap modulo 2^CNT_WIDTH.
- grant_owner reflects the current state.

Test Plan:
- Reset, then cpu_valid=1, addr=0x100, wstrb=0, memory always ready with rdata=0x1234_5678 → cycle 1: mem_valid=1, mem_addr=0x100, mem_instr=cpu_instr; cpu_ready=1 with rdata=0x1234_5678; cycle 2 IDLE; cpu_grants=1.
- cpu_valid and fpu_valid both asserted in the same cycle, held continuously, memory always ready, MAX_WAIT=4 → CPU is granted in cycles 1 and 3; fpu_ready first pulses in cycle 5; fpu_grants=1.
- FPU write addr=0x2000, wdata=0xCAFE_F00D, wstrb=0xF, mem_ready delayed 3 cycles → mem_wstrb=0xF and mem_instr=0 throughout; fpu_ready pulses exactly once, in cycle 4; cpu_ready stays 0.
- CPU request with mem_ready stuck at 0, TIMEOUT=64 → cpu_ready=1 with rdata=0 in cycle 64; timeout_err=1 from cycle 65; cpu_grants=0; a subsequent FPU request is served normally.
- Reset asserted in cycle 2 of a stalled FPU grant → from the next cycle: mem_valid=0, grant_owner=00, counters=0, no fpu_ready pulse.
